// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory port arbiter.
// Holds the funct3 load/store width encodings, the arbiter FSM state
// encoding and a helper that classifies a core access as misaligned.
package dmem_pkg;

    // funct3 encodings for loads/stores (RV32I)
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_C_RD = 2'b01,
        ST_E_RD = 2'b10
    } dmem_state_t;

    // Returns 1 when the access cannot be issued: halfword on an odd
    // address, word not on a 4-byte boundary, or an encoding that has no
    // load/store meaning (011, 110, 111).
    function automatic logic f3Misalign(input logic [2:0] funct3,
                                        input logic [1:0] addrLo);
        logic bad;
        case (funct3)
            F3_B, F3_BU: bad = 1'b0;
            F3_H, F3_HU: bad = addrLo[0];
            F3_W:        bad = (addrLo != 2'b00);
            default:     bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane alignment for the data-memory port (purely combinational).
// Store direction: funct3 + addrLo + right-justified data -> byte enables,
//   lane-replicated write data and the misalign flag.
// Load direction: funct3 + addrLo + raw memory word -> shifted and
//   sign/zero-extended load result.
// Ports:
//   stFunct3, stAddrLo, stData  : store-direction inputs (current access)
//   stBe, stLaneData, misalign  : store-direction results
//   ldFunct3, ldAddrLo, ldData  : load-direction inputs (captured access)
//   ldResult                    : extended load result
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]  stFunct3,
    input  logic [1:0]  stAddrLo,
    input  logic [31:0] stData,
    output logic [3:0]  stBe,
    output logic [31:0] stLaneData,
    output logic        misalign,
    input  logic [2:0]  ldFunct3,
    input  logic [1:0]  ldAddrLo,
    input  logic [31:0] ldData,
    output logic [31:0] ldResult
);

    logic [31:0] ldShift_s;

    // Store byte enables and replicated lane data; width taken from funct3[1:0]
    always_comb begin
        stBe       = 4'b0000;
        stLaneData = 32'h0000_0000;
        misalign   = f3Misalign(stFunct3, stAddrLo);
        case (stFunct3[1:0])
            2'b00: begin
                stBe       = 4'b0001 << stAddrLo;
                stLaneData = {4{stData[7:0]}};
            end
            2'b01: begin
                if (stAddrLo[1]) begin
                    stBe = 4'b1100;
                end else begin
                    stBe = 4'b0011;
                end
                stLaneData = {2{stData[15:0]}};
            end
            2'b10: begin
                stBe       = 4'b1111;
                stLaneData = stData;
            end
            default: begin
                stBe       = 4'b0000;
                stLaneData = 32'h0000_0000;
            end
        endcase
    end

    // Load result: move the addressed lane to bit 0, then extend
    always_comb begin
        ldShift_s = ldData >> {ldAddrLo, 3'b000};
        case (ldFunct3)
            F3_B:    ldResult = {{24{ldShift_s[7]}}, ldShift_s[7:0]};
            F3_BU:   ldResult = {24'h00_0000, ldShift_s[7:0]};
            F3_H:    ldResult = {{16{ldShift_s[15]}}, ldShift_s[15:0]};
            F3_HU:   ldResult = {16'h0000, ldShift_s[15:0]};
            F3_W:    ldResult = ldShift_s;
            default: ldResult = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Single-port data memory arbiter between the core MEM stage (port C) and
// an external loader/debug master (port E).
// Ports:
//   clk, rst                      : clock, asynchronous active-high reset
//   c_req/c_we/c_funct3/c_addr/c_wdata : core access request
//   c_stall                       : hold MEM and earlier stages
//   c_rdata/c_rvalid              : extended core load result (one-cycle pulse)
//   c_misalign                    : misaligned/unsupported core access pulse
//   e_req/e_we/e_addr/e_wdata     : external word request, held until e_gnt
//   e_gnt                         : external request accepted this cycle
//   e_rdata/e_rvalid              : raw external read data, cycle after grant
//   m_en/m_we/m_be/m_addr/m_wdata : memory macro request
//   m_rdata                       : memory read data, cycle after a read
// The memory side is driven in the same cycle as the request because the
// macro returns data one cycle after m_en; all outputs are forced to 0
// while rst is high.
module dmem_port_arbiter
    import dmem_pkg::*;
#(
    parameter int AW           = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [2:0]    c_funct3,
    input  logic [AW-1:0] c_addr,
    input  logic [31:0]   c_wdata,
    output logic          c_stall,
    output logic [31:0]   c_rdata,
    output logic          c_rvalid,
    output logic          c_misalign,
    input  logic          e_req,
    input  logic          e_we,
    input  logic [AW-1:0] e_addr,
    input  logic [31:0]   e_wdata,
    output logic          e_gnt,
    output logic [31:0]   e_rdata,
    output logic          e_rvalid,
    output logic          m_en,
    output logic          m_we,
    output logic [3:0]    m_be,
    output logic [AW-1:0] m_addr,
    output logic [31:0]   m_wdata,
    input  logic [31:0]   m_rdata
);

    localparam logic [AW-1:0] WORD_MASK = ~AW'(3);
    localparam logic [3:0]    LIMIT     = 4'(STARVE_LIMIT);

    dmem_state_t state_r;
    logic [3:0]  starveCnt_r;
    logic [2:0]  ldFunct3_r;
    logic [1:0]  ldAddrLo_r;

    logic        eWin_s;
    logic        cWin_s;
    logic        cAccess_s;
    logic        cLoad_s;
    logic        misalign_s;
    logic [3:0]  stBe_s;
    logic [31:0] stLane_s;
    logic [31:0] ldResult_s;

    dmem_lane_align uAlign (
        .stFunct3   (c_funct3),
        .stAddrLo   (c_addr[1:0]),
        .stData     (c_wdata),
        .stBe       (stBe_s),
        .stLaneData (stLane_s),
        .misalign   (misalign_s),
        .ldFunct3   (ldFunct3_r),
        .ldAddrLo   (ldAddrLo_r),
        .ldData     (m_rdata),
        .ldResult   (ldResult_s)
    );

    // Arbitration: only IDLE grants; E wins when C is idle or E has starved
    always_comb begin
        eWin_s    = 1'b0;
        cWin_s    = 1'b0;
        cAccess_s = 1'b0;
        cLoad_s   = 1'b0;
        if (state_r == ST_IDLE) begin
            eWin_s    = e_req && (!c_req || (starveCnt_r == LIMIT));
            cWin_s    = c_req && !eWin_s;
            cAccess_s = cWin_s && !misalign_s;
            cLoad_s   = cAccess_s && !c_we;
        end else begin
            eWin_s    = 1'b0;
            cWin_s    = 1'b0;
            cAccess_s = 1'b0;
            cLoad_s   = 1'b0;
        end
    end

    // Output drive; everything is held at 0 while reset is asserted
    always_comb begin
        c_stall    = 1'b0;
        c_rdata    = 32'h0000_0000;
        c_rvalid   = 1'b0;
        c_misalign = 1'b0;
        e_gnt      = 1'b0;
        e_rdata    = 32'h0000_0000;
        e_rvalid   = 1'b0;
        m_en       = 1'b0;
        m_we       = 1'b0;
        m_be       = 4'b0000;
        m_addr     = '0;
        m_wdata    = 32'h0000_0000;
        if (!rst) begin
            // The core is held during its own load issue and whenever E
            // occupies the memory (grant cycle or read-data cycle).
            c_stall    = cLoad_s || (c_req && (eWin_s || (state_r == ST_E_RD)));
            c_misalign = cWin_s && misalign_s;
            e_gnt      = eWin_s;
            if (state_r == ST_C_RD) begin
                c_rvalid = 1'b1;
                c_rdata  = ldResult_s;
            end else begin
                c_rvalid = 1'b0;
                c_rdata  = 32'h0000_0000;
            end
            if (state_r == ST_E_RD) begin
                e_rvalid = 1'b1;
                e_rdata  = m_rdata;
            end else begin
                e_rvalid = 1'b0;
                e_rdata  = 32'h0000_0000;
            end
            if (eWin_s) begin
                m_en    = 1'b1;
                m_we    = e_we;
                m_be    = 4'b1111;
                m_addr  = e_addr & WORD_MASK;
                m_wdata = e_wdata;
            end else if (cAccess_s) begin
                m_en    = 1'b1;
                m_we    = c_we;
                m_be    = stBe_s;
                m_addr  = c_addr & WORD_MASK;
                if (c_we) begin
                    m_wdata = stLane_s;
                end else begin
                    m_wdata = 32'h0000_0000;
                end
            end else begin
                m_en    = 1'b0;
                m_we    = 1'b0;
                m_be    = 4'b0000;
                m_addr  = '0;
                m_wdata = 32'h0000_0000;
            end
        end else begin
            c_stall = 1'b0;
        end
    end

    // FSM, starvation counter and captured load attributes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            starveCnt_r <= 4'd0;
            ldFunct3_r  <= 3'b000;
            ldAddrLo_r  <= 2'b00;
        end else begin
            if (eWin_s) begin
                starveCnt_r <= 4'd0;
            end else if (e_req && (starveCnt_r != 4'd15)) begin
                starveCnt_r <= starveCnt_r + 4'd1;
            end else begin
                starveCnt_r <= starveCnt_r;
            end
            case (state_r)
                ST_IDLE: begin
                    if (eWin_s && !e_we) begin
                        state_r <= ST_E_RD;
                    end else if (cLoad_s) begin
                        state_r    <= ST_C_RD;
                        ldFunct3_r <= c_funct3;
                        ldAddrLo_r <= c_addr[1:0];
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_C_RD: state_r <= ST_IDLE;
                ST_E_RD: state_r <= ST_IDLE;
                default: state_r <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with hand-computed expectations.
module tb_dmem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        c_req;
    logic        c_we;
    logic [2:0]  c_funct3;
    logic [31:0] c_addr;
    logic [31:0] c_wdata;
    logic        c_stall;
    logic [31:0] c_rdata;
    logic        c_rvalid;
    logic        c_misalign;
    logic        e_req;
    logic        e_we;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic        e_gnt;
    logic [31:0] e_rdata;
    logic        e_rvalid;
    logic        m_en;
    logic        m_we;
    logic [3:0]  m_be;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;

    int checks;
    int failures;

    dmem_port_arbiter #(.AW(32), .STARVE_LIMIT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .c_req      (c_req),
        .c_we       (c_we),
        .c_funct3   (c_funct3),
        .c_addr     (c_addr),
        .c_wdata    (c_wdata),
        .c_stall    (c_stall),
        .c_rdata    (c_rdata),
        .c_rvalid   (c_rvalid),
        .c_misalign (c_misalign),
        .e_req      (e_req),
        .e_we       (e_we),
        .e_addr     (e_addr),
        .e_wdata    (e_wdata),
        .e_gnt      (e_gnt),
        .e_rdata    (e_rdata),
        .e_rvalid   (e_rvalid),
        .m_en       (m_en),
        .m_we       (m_we),
        .m_be       (m_be),
        .m_addr     (m_addr),
        .m_wdata    (m_wdata),
        .m_rdata    (m_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are changed 1 time unit after the edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic coreReq(input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd);
        c_req    = 1'b1;
        c_we     = we;
        c_funct3 = f3;
        c_addr   = addr;
        c_wdata  = wd;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        c_req    = 1'b1;
        c_we     = 1'b0;
        c_funct3 = 3'b010;
        c_addr   = 32'h0000_0000;
        c_wdata  = 32'h0000_0000;
        e_req    = 1'b1;
        e_we     = 1'b0;
        e_addr   = 32'h0000_0000;
        e_wdata  = 32'h0000_0000;
        m_rdata  = 32'hFFFF_FFFF;

        // Reset: outputs held at 0 even with requests present
        #2;
        chk("rst_m_en", {31'd0, m_en}, 32'd0);
        chk("rst_c_stall", {31'd0, c_stall}, 32'd0);
        chk("rst_e_gnt", {31'd0, e_gnt}, 32'd0);
        chk("rst_e_rdata", e_rdata, 32'd0);
        c_req = 1'b0;
        e_req = 1'b0;
        m_rdata = 32'h0000_0000;
        #10;
        rst = 1'b0;
        cyc();

        // sb addr 0x103
        coreReq(1'b1, 3'b000, 32'h0000_0103, 32'h0000_00A5);
        #1;
        chk("sb_be", {28'd0, m_be}, 32'h8);
        chk("sb_wdata", m_wdata, 32'hA5A5_A5A5);
        chk("sb_addr", m_addr, 32'h0000_0100);
        chk("sb_stall", {31'd0, c_stall}, 32'd0);
        chk("sb_en_we", {30'd0, m_en, m_we}, 32'h3);
        cyc();

        // sh addr 0x102
        coreReq(1'b1, 3'b001, 32'h0000_0102, 32'h1234_BEEF);
        #1;
        chk("sh_be", {28'd0, m_be}, 32'hC);
        chk("sh_wdata", m_wdata, 32'hBEEF_BEEF);
        cyc();

        // sw addr 0x104
        coreReq(1'b1, 3'b010, 32'h0000_0104, 32'hCAFE_F00D);
        #1;
        chk("sw_be", {28'd0, m_be}, 32'hF);
        chk("sw_wdata", m_wdata, 32'hCAFE_F00D);
        chk("sw_addr", m_addr, 32'h0000_0104);
        cyc();

        // lb addr 0x102: issue stalls, data next cycle
        coreReq(1'b0, 3'b000, 32'h0000_0102, 32'h0);
        #1;
        chk("lb_iss_stall", {31'd0, c_stall}, 32'd1);
        chk("lb_iss_en_we", {30'd0, m_en, m_we}, 32'h2);
        chk("lb_iss_addr", m_addr, 32'h0000_0100);
        cyc();
        m_rdata = 32'h12F0_3456;
        #1;
        chk("lb_rvalid", {31'd0, c_rvalid}, 32'd1);
        chk("lb_rdata", c_rdata, 32'hFFFF_FFF0);
        chk("lb_rd_stall", {31'd0, c_stall}, 32'd0);
        chk("lb_rd_en", {31'd0, m_en}, 32'd0);
        cyc();

        // lbu same address
        coreReq(1'b0, 3'b100, 32'h0000_0102, 32'h0);
        m_rdata = 32'h0000_0000;
        #1;
        chk("lbu_iss_stall", {31'd0, c_stall}, 32'd1);
        cyc();
        m_rdata = 32'h12F0_3456;
        #1;
        chk("lbu_rdata", c_rdata, 32'h0000_00F0);
        cyc();

        // lh addr 0x100, negative halfword
        coreReq(1'b0, 3'b001, 32'h0000_0100, 32'h0);
        #1;
        cyc();
        m_rdata = 32'h12F0_8456;
        #1;
        chk("lh_rdata", c_rdata, 32'hFFFF_8456);
        cyc();

        // lhu addr 0x102
        coreReq(1'b0, 3'b101, 32'h0000_0102, 32'h0);
        #1;
        cyc();
        m_rdata = 32'h92F0_8456;
        #1;
        chk("lhu_rdata", c_rdata, 32'h0000_92F0);
        cyc();
        c_req = 1'b0;
        #1;
        chk("idle_rvalid", {31'd0, c_rvalid}, 32'd0);
        cyc();

        // Misaligned lw addr 0x206
        coreReq(1'b0, 3'b010, 32'h0000_0206, 32'h0);
        #1;
        chk("mis_lw_flag", {31'd0, c_misalign}, 32'd1);
        chk("mis_lw_en", {31'd0, m_en}, 32'd0);
        chk("mis_lw_stall", {31'd0, c_stall}, 32'd0);
        cyc();
        chk("mis_lw_norv", {31'd0, c_rvalid}, 32'd0);
        // Misaligned sh, unsupported funct3
        coreReq(1'b1, 3'b001, 32'h0000_0101, 32'h0);
        #1;
        chk("mis_sh_flag_en", {30'd0, c_misalign, m_en}, 32'h2);
        cyc();
        coreReq(1'b0, 3'b011, 32'h0000_0100, 32'h0);
        #1;
        chk("mis_f3_flag_en", {30'd0, c_misalign, m_en}, 32'h2);
        cyc();

        // Starvation: C stores every cycle, E write force-granted on 5th cycle
        e_req   = 1'b1;
        e_we    = 1'b1;
        e_addr  = 32'h0000_0200;
        e_wdata = 32'h5555_AAAA;
        for (int i = 1; i <= 5; i++) begin
            coreReq(1'b1, 3'b010, 32'h0000_0010, 32'h0000_1111);
            #1;
            if (i < 5) begin
                chk($sformatf("starve_deny%0d", i), {30'd0, e_gnt, c_stall}, 32'h0);
                chk($sformatf("starve_caddr%0d", i), m_addr, 32'h0000_0010);
            end else begin
                chk("starve_gnt", {30'd0, e_gnt, c_stall}, 32'h3);
                chk("starve_maddr", m_addr, 32'h0000_0200);
                chk("starve_wdata", m_wdata, 32'h5555_AAAA);
                chk("starve_be_we", {27'd0, m_be, m_we}, 32'h1F);
            end
            cyc();
        end
        // Counter cleared: a fresh E request loses to C again
        #1;
        chk("starve_clear", {30'd0, e_gnt, c_stall}, 32'h0);
        chk("starve_c_again", m_addr, 32'h0000_0010);
        cyc();
        c_req = 1'b0;
        e_req = 1'b0;
        cyc();

        // External read addr 0x43 with C idle
        e_req  = 1'b1;
        e_we   = 1'b0;
        e_addr = 32'h0000_0043;
        #1;
        chk("ext_gnt", {31'd0, e_gnt}, 32'd1);
        chk("ext_en_we_be", {26'd0, m_en, m_we, m_be}, 32'h2F);
        chk("ext_addr", m_addr, 32'h0000_0040);
        cyc();
        e_req   = 1'b0;
        m_rdata = 32'hDEAD_BEEF;
        coreReq(1'b0, 3'b010, 32'h0000_0080, 32'h0);
        #1;
        chk("ext_rvalid", {31'd0, e_rvalid}, 32'd1);
        chk("ext_rdata", e_rdata, 32'hDEAD_BEEF);
        chk("ext_core_stall", {30'd0, c_stall, m_en}, 32'h2);
        cyc();
        m_rdata = 32'h0000_0000;
        #1;
        chk("ext_rv_drop", {31'd0, e_rvalid}, 32'd0);
        chk("ext_core_issue", {30'd0, c_stall, m_en}, 32'h3);
        chk("ext_core_addr", m_addr, 32'h0000_0080);
        cyc();
        m_rdata = 32'h1122_3344;
        #1;
        chk("ext_core_rdata", c_rdata, 32'h1122_3344);
        chk("ext_core_rvalid", {31'd0, c_rvalid}, 32'd1);
        cyc();
        c_req = 1'b0;
        cyc();

        // Reset asserted during C_RD
        coreReq(1'b0, 3'b010, 32'h0000_0000, 32'h0);
        #1;
        cyc();
        m_rdata = 32'h7777_7777;
        rst     = 1'b1;
        #1;
        chk("rst_crd_rvalid", {31'd0, c_rvalid}, 32'd0);
        chk("rst_crd_rdata", c_rdata, 32'd0);
        chk("rst_crd_stall_en", {30'd0, c_stall, m_en}, 32'h0);
        c_req = 1'b0;
        #2;
        rst = 1'b0;
        cyc();
        chk("rst_post_rvalid", {31'd0, c_rvalid}, 32'd0);
        chk("rst_post_rdata", c_rdata, 32'd0);
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
